// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes for the divider and the
// div_sequencer state encoding.
package cpu_pkg;

    localparam int ALUCONTROL_WIDTH = 6;
    localparam logic [ALUCONTROL_WIDTH-1:0] UDIV = 6'b101110;
    localparam logic [ALUCONTROL_WIDTH-1:0] SDIV = 6'b101111;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPrep = 3'd1,
        StIter = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } divStateT;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] remCur,
    input  logic [WIDTH-1:0] quoCur,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        shifted = {remCur, quoCur[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        // When the divisor fits, the true difference is below 2^WIDTH.
        diff    = shifted[WIDTH-1:0] - divisor;
        remNext = fits ? diff : shifted[WIDTH-1:0];
        quoNext = {quoCur[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle UDIV/SDIV sequencer: captures operands, runs WIDTH restoring
// steps, fixes the sign and pulses done with the quotient.
module div_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero
);

    localparam int unsigned CountW = $clog2(WIDTH) + 1;
    localparam logic [CountW-1:0] LastCount = CountW'(WIDTH - 1);

    divStateT          state;
    logic [WIDTH-1:0]  dividendReg;
    logic [WIDTH-1:0]  divisorReg;
    logic [WIDTH-1:0]  remReg;
    logic [WIDTH-1:0]  quoReg;
    logic [WIDTH-1:0]  remNext;
    logic [WIDTH-1:0]  quoNext;
    logic [WIDTH-1:0]  quoFixed;
    logic              signedReg;
    logic              negReg;
    logic [CountW-1:0] count;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remCur (remReg),
        .quoCur (quoReg),
        .divisor(divisorReg),
        .remNext(remNext),
        .quoNext(quoNext)
    );

    assign quoFixed = negReg ? (~quoReg + 1'b1) : quoReg;
    assign busy     = (state != StIdle);
    assign stall    = (start & ~flush & (state == StIdle))
                    | (state inside {StPrep, StIter, StFix});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            dividendReg <= '0;
            divisorReg  <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            signedReg   <= 1'b0;
            negReg      <= 1'b0;
            count       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush && state != StIdle) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (start && !flush) begin
                            dividendReg <= dividend;
                            divisorReg  <= divisor;
                            signedReg   <= signed_op;
                            state       <= StPrep;
                        end
                    end
                    StPrep: begin
                        quoReg     <= (signedReg && dividendReg[WIDTH-1]) ? -dividendReg
                                                                          : dividendReg;
                        divisorReg <= (signedReg && divisorReg[WIDTH-1]) ? -divisorReg
                                                                         : divisorReg;
                        negReg     <= signedReg & (dividendReg[WIDTH-1] ^ divisorReg[WIDTH-1]);
                        remReg     <= '0;
                        count      <= '0;
                        if (divisorReg == '0) begin
                            quotient    <= '0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= StDone;
                        end else begin
                            state <= StIter;
                        end
                    end
                    StIter: begin
                        remReg <= remNext;
                        quoReg <= quoNext;
                        count  <= count + 1'b1;
                        if (count == LastCount) state <= StFix;
                    end
                    StFix: begin
                        // Result lands with done so it is valid during the DONE cycle.
                        quotient <= quoFixed;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
